sync_fifo_v2: RTL and testbench

//   Parametrised single-clock FIFO that replaces the fixed 8x4 buffer.
//   - Any depth >= 2, not only powers of two. Pointers wrap explicitly.
//   - Exact occupancy count, programmable almost-full and almost-empty flags.
//   - Selectable read mode: registered read or first-word-fall-through.
//   - Sticky overflow and underflow error flags, plus a synchronous flush.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 26 ++
 rtl/sync_fifo_v2.sv | 122 ++++++++++++
 tb/tb_sync_fifo_v2.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: read-mode encoding and count sizing.
package fifo_pkg;

    typedef enum logic {
        FIFO_REG  = 1'b0,
        FIFO_FWFT = 1'b1
    } read_mode_e;

    // Bits needed to hold an occupancy in the closed range [0, depth].
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, combinational read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; occupancy tracking makes stale words invisible.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO of arbitrary depth with exact count, threshold flags,
// selectable registered / fall-through read, sticky error flags and flush.
module sync_fifo_v2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      wr_en_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic                      rd_en_i,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic                      rd_valid_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      almost_full_o,
    output logic                      almost_empty_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);

    localparam int         CW   = cnt_w(DEPTH);
    localparam int         AW   = $clog2(DEPTH);
    localparam read_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_v2: DEPTH must be at least 2");
        end
        if (AF_LEVEL > DEPTH) begin : g_bad_af
            $error("sync_fifo_v2: AF_LEVEL must not exceed DEPTH");
        end
    endgenerate

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  pop_acc;
    logic                  push_acc;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;
    logic                  ovf_q;
    logic                  unf_q;

    assign empty_o        = (count == '0);
    assign full_o         = (count == CW'(DEPTH));
    assign almost_full_o  = (count >= CW'(AF_LEVEL));
    assign almost_empty_o = (count <= CW'(AE_LEVEL));
    assign count_o        = count;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

    // A pop frees a slot in the same edge, so a full FIFO can still take a push alongside it.
    assign pop_acc  = rd_en_i & ~empty_o;
    assign push_acc = wr_en_i & (~full_o | pop_acc);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (push_acc & ~clr_i),
        .wr_addr_i (wr_ptr),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_ptr),
        .rd_data_o (mem_rd)
    );

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= ptr_next(wr_ptr);
            if (pop_acc)  rd_ptr <= ptr_next(rd_ptr);
            if (push_acc && !pop_acc)      count <= count + 1'b1;
            else if (pop_acc && !push_acc) count <= count - 1'b1;
            if (wr_en_i && !push_acc) ovf_q <= 1'b1;
            if (rd_en_i && empty_o)   unf_q <= 1'b1;
        end
    end

    // ---- read stage p1: registered output word and its valid ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else if (clr_i) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= pop_acc;
            if (pop_acc) rd_data_p1 <= mem_rd;
        end
    end

    assign rd_data_o  = (MODE == FIFO_FWFT) ? mem_rd   : rd_data_p1;
    assign rd_valid_o = (MODE == FIFO_FWFT) ? ~empty_o : vld_p1;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench for sync_fifo_v2: one registered-read and one fall-through instance.
module tb_sync_fifo_v2;

    localparam int DW = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          r_clr = 0, r_wr = 0, r_rd = 0;
    logic [DW-1:0] r_wd  = '0;
    logic [DW-1:0] r_rdata;
    logic          r_vld, r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic [CW-1:0] r_cnt;

    logic          f_clr = 0, f_wr = 0, f_rd = 0;
    logic [DW-1:0] f_wd  = '0;
    logic [DW-1:0] f_rdata;
    logic          f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] f_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_reg (
        .clk_i(clk), .rst_i(rst), .clr_i(r_clr), .wr_en_i(r_wr), .wr_data_i(r_wd),
        .rd_en_i(r_rd), .rd_data_o(r_rdata), .rd_valid_o(r_vld), .full_o(r_full),
        .empty_o(r_empty), .almost_full_o(r_af), .almost_empty_o(r_ae),
        .count_o(r_cnt), .overflow_o(r_ovf), .underflow_o(r_unf)
    );

    sync_fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_i(rst), .clr_i(f_clr), .wr_en_i(f_wr), .wr_data_i(f_wd),
        .rd_en_i(f_rd), .rd_data_o(f_rdata), .rd_valid_o(f_vld), .full_o(f_full),
        .empty_o(f_empty), .almost_full_o(f_af), .almost_empty_o(f_ae),
        .count_o(f_cnt), .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic r_push(input logic [DW-1:0] d);
        r_wr = 1'b1;
        r_wd = d;
        tick();
        r_wr = 1'b0;
    endtask

    task automatic r_pop_chk(input string tag, input logic [DW-1:0] exp);
        r_rd = 1'b1;
        tick();
        r_rd = 1'b0;
        chk({tag, "_vld"}, r_vld, 1'b1);
        chk({tag, "_data"}, r_rdata, exp);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_empty", r_empty, 1'b1);
        chk("rst_full", r_full, 1'b0);
        chk("rst_ae", r_ae, 1'b1);
        chk("rst_cnt", r_cnt, 0);
        chk("rst_vld", r_vld, 1'b0);
        chk("rst_data", r_rdata, 0);
        chk("rst_ovf", r_ovf, 1'b0);
        chk("rst_unf", r_unf, 1'b0);
        chk("rst_f_vld", f_vld, 1'b0);
        rst = 1'b0;

        // 1: push 3,7,9 then pop three times
        r_push(4'h3);
        r_push(4'h7);
        r_push(4'h9);
        chk("t1_cnt", r_cnt, 3);
        chk("t1_vld_idle", r_vld, 1'b0);
        r_pop_chk("t1_pop0", 4'h3);
        r_pop_chk("t1_pop1", 4'h7);
        r_pop_chk("t1_pop2", 4'h9);
        tick();
        chk("t1_vld_drop", r_vld, 1'b0);
        chk("t1_data_hold", r_rdata, 4'h9);
        chk("t1_empty", r_empty, 1'b1);

        // 2: fill to 5, then overflow
        r_push(4'h1);
        r_push(4'h2);
        r_push(4'h3);
        chk("t2_af3", r_af, 1'b0);
        chk("t2_ae3", r_ae, 1'b0);
        r_push(4'h4);
        chk("t2_af4", r_af, 1'b1);
        chk("t2_full4", r_full, 1'b0);
        r_push(4'h5);
        chk("t2_full", r_full, 1'b1);
        chk("t2_cnt", r_cnt, 5);
        chk("t2_ovf_pre", r_ovf, 1'b0);
        r_push(4'hF);
        chk("t2_ovf", r_ovf, 1'b1);
        chk("t2_cnt_ovf", r_cnt, 5);

        // 3: push A and pop while full; oldest comes out, A last
        r_wr = 1'b1;
        r_wd = 4'hA;
        r_rd = 1'b1;
        tick();
        r_wr = 1'b0;
        r_rd = 1'b0;
        chk("t3_cnt", r_cnt, 5);
        chk("t3_data", r_rdata, 4'h1);
        chk("t3_full", r_full, 1'b1);
        r_pop_chk("t3_pop2", 4'h2);
        r_pop_chk("t3_pop3", 4'h3);
        r_pop_chk("t3_pop4", 4'h4);
        r_pop_chk("t3_pop5", 4'h5);
        r_pop_chk("t3_popA", 4'hA);
        chk("t3_empty", r_empty, 1'b1);
        chk("t3_ovf_sticky", r_ovf, 1'b1);

        // 5: underflow, then push+pop while empty
        chk("t5_unf_pre", r_unf, 1'b0);
        r_rd = 1'b1;
        tick();
        r_rd = 1'b0;
        chk("t5_unf", r_unf, 1'b1);
        chk("t5_vld", r_vld, 1'b0);
        r_wr = 1'b1;
        r_wd = 4'h6;
        r_rd = 1'b1;
        tick();
        r_wr = 1'b0;
        r_rd = 1'b0;
        chk("t5_cnt", r_cnt, 1);
        chk("t5_unf_hold", r_unf, 1'b1);
        chk("t5_vld_rej", r_vld, 1'b0);

        // 6a: three stored, flush together with a push
        r_push(4'h7);
        r_push(4'h8);
        chk("t6_cnt3", r_cnt, 3);
        r_clr = 1'b1;
        r_wr = 1'b1;
        r_wd = 4'hB;
        tick();
        r_clr = 1'b0;
        r_wr = 1'b0;
        chk("t6_clr_cnt", r_cnt, 0);
        chk("t6_clr_empty", r_empty, 1'b1);
        chk("t6_clr_ovf", r_ovf, 1'b0);
        chk("t6_clr_unf", r_unf, 1'b0);
        r_push(4'hC);
        r_pop_chk("t6_after_clr", 4'hC);

        // 4: fall-through instance shows the word before any pop
        f_wr = 1'b1;
        f_wd = 4'hC;
        tick();
        f_wr = 1'b0;
        chk("t4_vld", f_vld, 1'b1);
        chk("t4_data", f_rdata, 4'hC);
        chk("t4_cnt", f_cnt, 1);
        f_wr = 1'b1;
        f_wd = 4'hD;
        tick();
        f_wd = 4'hE;
        tick();
        f_wr = 1'b0;
        f_rd = 1'b1;
        tick();
        chk("t4_next_D", f_rdata, 4'hD);
        tick();
        chk("t4_next_E", f_rdata, 4'hE);
        tick();
        f_rd = 1'b0;
        chk("t4_empty_vld", f_vld, 1'b0);
        chk("t4_empty", f_empty, 1'b1);

        // 6b: asynchronous reset between clock edges
        r_push(4'h4);
        r_push(4'h5);
        r_push(4'h6);
        f_wr = 1'b1;
        f_wd = 4'h9;
        r_rd = 1'b1;
        tick();
        r_rd = 1'b0;
        f_wr = 1'b0;
        chk("t6b_pre_vld", r_vld, 1'b1);
        chk("t6b_pre_data", r_rdata, 4'h4);
        chk("t6b_pre_cnt", r_cnt, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6b_cnt", r_cnt, 0);
        chk("t6b_empty", r_empty, 1'b1);
        chk("t6b_vld", r_vld, 1'b0);
        chk("t6b_data", r_rdata, 0);
        chk("t6b_ae", r_ae, 1'b1);
        chk("t6b_f_vld", f_vld, 1'b0);
        chk("t6b_f_cnt", f_cnt, 0);
        rst = 1'b0;
        tick();
        chk("t6b_post_empty", r_empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
